// File: rtl/seq_window_checker.sv
// -----------------------------------------------------------------------------
// seq_window_checker
//
// In-silicon monitor for the temporal property
//     (a == cfg_a_val) ##[DMIN:DMAX] (b == cfg_b_val)
// Every overlapping attempt is tracked by its age in a one-hot-per-age shift
// register. Each attempt passes at the first in-window cycle where the
// consequent holds, or fails when it reaches age DMAX without it.
//
// Optional feature (macro SEQ_CHK_FAIL_CAPTURE_EN):
//   adds a free-running cycle counter and records the cycle of the first fail
//   seen since reset or clr_cnt.
//
// Ports:
//   clk              clock, all sampling on posedge
//   rst_n            asynchronous active-low reset
//   en               checker enable; low flushes all attempts in flight
//   clr_cnt          synchronous clear of the pass/fail counters
//   a, b             antecedent / consequent buses
//   cfg_a_val        antecedent compare value
//   cfg_b_val        consequent compare value
//   pass, fail       registered pulses: at least one attempt passed / failed
//   pass_num         number of attempts that passed on the deciding edge
//   fail_num         number of attempts that failed (0 or 1)
//   pass_cnt         saturating total of passes
//   fail_cnt         saturating total of fails
//   pending          one or more attempts in flight
//   first_fail_valid (feature only) a fail has been captured
//   first_fail_cycle (feature only) cycle count of the first fail's edge
// -----------------------------------------------------------------------------
module seq_window_checker #(
    parameter int unsigned DW   = 32,
    parameter int unsigned DMIN = 5,
    parameter int unsigned DMAX = 5,
    parameter int unsigned CW   = 16,
    parameter int unsigned NW   = $clog2(DMAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr_cnt,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] cfg_a_val,
    input  logic [DW-1:0] cfg_b_val,
    output logic          pass,
    output logic          fail,
    output logic [NW-1:0] pass_num,
    output logic [NW-1:0] fail_num,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          pending
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
    ,
    output logic          first_fail_valid,
    output logic [31:0]   first_fail_cycle
`endif
);

    // pend[k] = 1: an attempt started k edges ago and is still undecided
    logic [DMAX:1] pend;
    logic [DMAX:1] pend_next;
    logic [DMAX:1] match;
    logic          ant;
    logic          cons;
    logic          expire;
    logic [NW-1:0] match_num;
    logic [CW:0]   pass_sum;
    logic [CW:0]   fail_sum;

    always_comb begin
        ant       = en && (a == cfg_a_val);
        cons      = (b == cfg_b_val);
        match     = '0;
        pend_next = '0;
        expire    = 1'b0;
        match_num = '0;
        if (en) begin
            for (int unsigned k = DMIN; k <= DMAX; k++) begin
                match[k] = pend[k] & cons;
            end
            expire       = pend[DMAX] & ~cons;
            pend_next[1] = ant;
            // An attempt that matched retires; age DMAX shifts out either way
            for (int unsigned k = 1; k < DMAX; k++) begin
                pend_next[k+1] = pend[k] & ~match[k];
            end
            for (int unsigned k = DMIN; k <= DMAX; k++) begin
                match_num = match_num + NW'(match[k]);
            end
        end
    end

    // One extra bit detects overflow so the counters can saturate
    always_comb begin
        pass_sum = {1'b0, pass_cnt} + (CW+1)'(match_num);
        fail_sum = {1'b0, fail_cnt} + (CW+1)'(expire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            pass_num <= '0;
            fail_num <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            pend     <= pend_next;
            pass     <= |match;
            fail     <= expire;
            pass_num <= match_num;
            fail_num <= NW'(expire);
            pending  <= |pend_next;
            if (clr_cnt) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
            end else begin
                pass_cnt <= pass_sum[CW] ? '1 : pass_sum[CW-1:0];
                fail_cnt <= fail_sum[CW] ? '1 : fail_sum[CW-1:0];
            end
        end
    end

`ifdef SEQ_CHK_FAIL_CAPTURE_EN
    // Counts edges since reset; the captured value is the count held just
    // before the deciding edge.
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_cycle <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (clr_cnt) begin
                first_fail_valid <= 1'b0;
                first_fail_cycle <= '0;
            end else if (expire && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_cycle <= cycle_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_window_checker.sv
module tb_seq_window_checker;

    localparam logic [31:0] AM = 32'd0;
    localparam logic [31:0] AN = 32'h55;
    localparam logic [31:0] BM = 32'd2;
    localparam logic [31:0] BN = 32'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, clr_cnt;
    logic [31:0] a, b, cfg_a, cfg_b;

    logic        pass0, fail0, pend0;
    logic [2:0]  pn0, fn0;
    logic [3:0]  pc0, fc0;
    logic        pass1, fail1, pend1;
    logic [2:0]  pn1, fn1;
    logic [15:0] pc1, fc1;
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
    logic        ffv0, ffv1;
    logic [31:0] ffc0, ffc1;
`endif

    seq_window_checker #(.DW(32), .DMIN(5), .DMAX(5), .CW(4)) u_fixed (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .a(a), .b(b), .cfg_a_val(cfg_a), .cfg_b_val(cfg_b),
        .pass(pass0), .fail(fail0), .pass_num(pn0), .fail_num(fn0),
        .pass_cnt(pc0), .fail_cnt(fc0), .pending(pend0)
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
        , .first_fail_valid(ffv0), .first_fail_cycle(ffc0)
`endif
    );

    seq_window_checker #(.DW(32), .DMIN(2), .DMAX(4), .CW(16)) u_window (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .a(a), .b(b), .cfg_a_val(cfg_a), .cfg_b_val(cfg_b),
        .pass(pass1), .fail(fail1), .pass_num(pn1), .fail_num(fn1),
        .pass_cnt(pc1), .fail_cnt(fc1), .pending(pend1)
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
        , .first_fail_valid(ffv1), .first_fail_cycle(ffc1)
`endif
    );

    typedef struct packed {
        logic        p;
        logic        f;
        logic [2:0]  pn;
        logic [2:0]  fn;
        logic [15:0] pc;
        logic [15:0] fc;
        logic        pend;
    } obs_t;

    obs_t o0, o1, e0, e1;
    assign o0 = {pass0, fail0, pn0, fn0, 12'd0, pc0, 12'd0, fc0, pend0};
    assign o1 = {pass1, fail1, pn1, fn1, pc1, fc1, pend1};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per-instance list of attempt start edges
    int   dmin_m [2] = '{5, 2};
    int   dmax_m [2] = '{5, 4};
    int   cmax_m [2] = '{15, 65535};
    bit   alive [2][0:4095];
    int   pc_m [2];
    int   fc_m [2];
    int   t = 0;
    obs_t q0[$];
    obs_t q1[$];
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
    int unsigned ecount = 0;
    bit          ffv_m = 0;
    int unsigned ffc_m = 0;
`endif

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 4096; s++) alive[i][s] = 1'b0;
            pc_m[i] = 0;
            fc_m[i] = 0;
        end
        q0.delete();
        q1.delete();
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
        ecount = 0;
        ffv_m  = 0;
        ffc_m  = 0;
`endif
    endtask

    // Drive one edge worth of stimulus, push expectations, advance past the edge
    task automatic step(input logic [31:0] av, input logic [31:0] bv,
                        input logic en_i, input logic clr_i);
        obs_t e;
        int   np, nf, nf0, age;
        bit   ant, cons, pnd;
        a = av; b = bv; en = en_i; clr_cnt = clr_i;
        ant  = en_i && (av == cfg_a);
        cons = (bv == cfg_b);
        nf0  = 0;
        for (int i = 0; i < 2; i++) begin
            np = 0; nf = 0;
            for (int s = t - dmax_m[i]; s < t; s++) begin
                if (s >= 0 && alive[i][s]) begin
                    age = t - s;
                    if (!en_i) alive[i][s] = 1'b0;
                    else if (age >= dmin_m[i] && cons) begin
                        np++; alive[i][s] = 1'b0;
                    end else if (age == dmax_m[i]) begin
                        nf++; alive[i][s] = 1'b0;
                    end
                end
            end
            alive[i][t] = ant;
            pnd = 1'b0;
            for (int s = t - dmax_m[i] + 1; s <= t; s++)
                if (s >= 0 && alive[i][s]) pnd = 1'b1;
            if (clr_i) begin
                pc_m[i] = 0; fc_m[i] = 0;
            end else begin
                pc_m[i] = (pc_m[i] + np > cmax_m[i]) ? cmax_m[i] : pc_m[i] + np;
                fc_m[i] = (fc_m[i] + nf > cmax_m[i]) ? cmax_m[i] : fc_m[i] + nf;
            end
            e = {np != 0, nf != 0, 3'(np), 3'(nf), 16'(pc_m[i]), 16'(fc_m[i]), pnd};
            if (i == 0) begin q0.push_back(e); nf0 = nf; end
            else q1.push_back(e);
        end
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
        if (clr_i) begin ffv_m = 0; ffc_m = 0; end
        else if (nf0 > 0 && !ffv_m) begin ffv_m = 1; ffc_m = ecount; end
        ecount++;
`endif
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr_cnt = 1'b0;
        a = AN; b = BN; cfg_a = AM; cfg_b = BM;
        #1;
        vectors += 2;
        if (o0 !== '0) begin miscompares++; $display("FAIL reset fixed got %h exp 0", o0); end
        if (o1 !== '0) begin miscompares++; $display("FAIL reset window got %h exp 0", o1); end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_fixed_pass();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL fixed_pass prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL fixed_pass prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 8; c++) begin
            step(c == 1 ? AM : AN, c == 6 ? BM : BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL fixed_pass edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL fixed_pass edge %0d window got %h exp %h", c, o1, e1); end
            if (c == 6) begin
                vectors++;
                if (pass0 !== 1'b1 || pn0 !== 3'd1 || fail0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fixed_pass pulse got pass=%b num=%0d fail=%b exp 1 1 0", pass0, pn0, fail0);
                end
            end
        end
        vectors++;
        if (pc0 !== 4'd1 || fc0 !== 4'd0 || pend0 !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_pass totals got pc=%0d fc=%0d pend=%b exp 1 0 0", pc0, fc0, pend0);
        end
    endtask

    task automatic test_fixed_fail();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL fixed_fail prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL fixed_fail prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 8; c++) begin
            step(c == 1 ? AM : AN, BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL fixed_fail edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL fixed_fail edge %0d window got %h exp %h", c, o1, e1); end
            if (c == 6) begin
                vectors++;
                if (fail0 !== 1'b1 || fn0 !== 3'd1 || pass0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fixed_fail pulse got fail=%b num=%0d pass=%b exp 1 1 0", fail0, fn0, pass0);
                end
            end
        end
        vectors++;
        if (pc0 !== 4'd0 || fc0 !== 4'd1) begin
            miscompares++;
            $display("FAIL fixed_fail totals got pc=%0d fc=%0d exp 0 1", pc0, fc0);
        end
    endtask

    task automatic test_overlap();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL overlap prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL overlap prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 10; c++) begin
            step(c <= 3 ? AM : AN, c == 7 ? BM : BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL overlap edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL overlap edge %0d window got %h exp %h", c, o1, e1); end
        end
        vectors++;
        if (pc0 !== 4'd1 || fc0 !== 4'd2) begin
            miscompares++;
            $display("FAIL overlap totals got pc=%0d fc=%0d exp 1 2", pc0, fc0);
        end
    endtask

    task automatic test_window();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL window prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL window prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 6; c++) begin
            step(c <= 2 ? AM : AN, c == 4 ? BM : BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL window edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL window edge %0d window got %h exp %h", c, o1, e1); end
            if (c == 4) begin
                vectors++;
                if (pn1 !== 3'd2) begin miscompares++; $display("FAIL window pass_num got %0d exp 2", pn1); end
            end
        end
        vectors++;
        if (pc1 !== 16'd2 || fc1 !== 16'd0) begin
            miscompares++;
            $display("FAIL window totals got pc=%0d fc=%0d exp 2 0", pc1, fc1);
        end
        // cons at age 1 is before the window and must not retire the attempt
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL early prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL early prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 6; c++) begin
            step(c == 1 ? AM : AN, c == 2 ? BM : BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL early edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL early edge %0d window got %h exp %h", c, o1, e1); end
        end
        vectors++;
        if (pc1 !== 16'd0 || fc1 !== 16'd1) begin
            miscompares++;
            $display("FAIL early totals got pc=%0d fc=%0d exp 0 1", pc1, fc1);
        end
    endtask

    task automatic test_saturation();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL sat prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL sat prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 25; c++) begin
            step(AM, BM, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL sat edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL sat edge %0d window got %h exp %h", c, o1, e1); end
        end
        vectors++;
        if (pc0 !== 4'd15) begin miscompares++; $display("FAIL sat pass_cnt got %0d exp 15", pc0); end
        step(AM, BM, 1'b1, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL sat clr fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL sat clr window got %h exp %h", o1, e1); end
        vectors++;
        if (pc0 !== 4'd0 || pass0 !== 1'b1) begin
            miscompares++;
            $display("FAIL sat clear got pc=%0d pass=%b exp 0 1", pc0, pass0);
        end
    endtask

    task automatic test_enable_flush();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL en_flush prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL en_flush prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 10; c++) begin
            step(c == 1 ? AM : AN, BN, c != 4, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL en_flush edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL en_flush edge %0d window got %h exp %h", c, o1, e1); end
        end
        vectors++;
        if (fc0 !== 4'd0 || fc1 !== 16'd0 || pend0 !== 1'b0) begin
            miscompares++;
            $display("FAIL en_flush totals got fc0=%0d fc1=%0d pend=%b exp 0 0 0", fc0, fc1, pend0);
        end
    endtask

    task automatic test_reset_flush();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL rst_flush prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL rst_flush prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 3; c++) begin
            step(c == 1 ? AM : AN, BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL rst_flush edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL rst_flush edge %0d window got %h exp %h", c, o1, e1); end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors += 2;
        if (o0 !== '0) begin miscompares++; $display("FAIL rst_flush async fixed got %h exp 0", o0); end
        if (o1 !== '0) begin miscompares++; $display("FAIL rst_flush async window got %h exp 0", o1); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step(AN, BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL rst_flush post %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL rst_flush post %0d window got %h exp %h", c, o1, e1); end
        end
        vectors++;
        if (fc0 !== 4'd0 || fail0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_flush totals got fc=%0d fail=%b exp 0 0", fc0, fail0);
        end
    endtask

    task automatic test_cfg_change();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL cfg prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL cfg prep window got %h exp %h", o1, e1); end
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) cfg_b = 32'd7;
            step(c == 1 ? AM : AN, c == 6 ? 32'd7 : BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL cfg edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL cfg edge %0d window got %h exp %h", c, o1, e1); end
        end
        cfg_b = BM;
        vectors++;
        if (pc0 !== 4'd1 || fc0 !== 4'd0) begin
            miscompares++;
            $display("FAIL cfg totals got pc=%0d fc=%0d exp 1 0", pc0, fc0);
        end
    endtask

`ifdef SEQ_CHK_FAIL_CAPTURE_EN
    task automatic test_capture();
        step(AN, BN, 1'b0, 1'b1);
        e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
        if (o0 !== e0) begin miscompares++; $display("FAIL capture prep fixed got %h exp %h", o0, e0); end
        if (o1 !== e1) begin miscompares++; $display("FAIL capture prep window got %h exp %h", o1, e1); end
        vectors++;
        if (ffv0 !== 1'b0) begin miscompares++; $display("FAIL capture cleared got valid=%b exp 0", ffv0); end
        for (int c = 1; c <= 12; c++) begin
            step((c == 1 || c == 3) ? AM : AN, BN, 1'b1, 1'b0);
            e0 = q0.pop_front(); e1 = q1.pop_front(); vectors += 2;
            if (o0 !== e0) begin miscompares++; $display("FAIL capture edge %0d fixed got %h exp %h", c, o0, e0); end
            if (o1 !== e1) begin miscompares++; $display("FAIL capture edge %0d window got %h exp %h", c, o1, e1); end
        end
        vectors++;
        if (ffv0 !== ffv_m || ffc0 !== ffc_m) begin
            miscompares++;
            $display("FAIL capture got valid=%b cycle=%0d exp %b %0d", ffv0, ffc0, ffv_m, ffc_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_pass();
        test_fixed_fail();
        test_overlap();
        test_window();
        test_saturation();
        test_enable_flush();
        test_reset_flush();
        test_cfg_change();
`ifdef SEQ_CHK_FAIL_CAPTURE_EN
        test_capture();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
